// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - ready/valid data bus between the load/store unit and memory
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit: one aligned bus access per request with lane steering,
// load extension, misalignment/reserved-size faults and a bus timeout
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        memSelect,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic              stall,
  mem_access_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  sel_q, sel_d;
  logic [1:0]  lane_q, lane_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  logic [1:0]  req_cause;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // Reserved size wins over misalignment when both apply.
  always_comb begin
    req_cause = 2'b00;
    if (memSelect[1:0] == 2'd3) begin
      req_cause = 2'b10;
    end else if ((memSelect[1:0] == 2'd1 && addr[0]) ||
                 (memSelect[1:0] == 2'd2 && addr[1:0] != 2'b00)) begin
      req_cause = 2'b01;
    end
  end

  always_comb begin
    case (memSelect[1:0])
      2'd0: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      2'd1: begin
        req_be    = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    rd_byte = bus.bus_rdata[{lane_q, 3'b000} +: 8];
    rd_half = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (sel_q[1:0])
      2'd0:    rd_ext = {{24{sel_q[2] & rd_byte[7]}}, rd_byte};
      2'd1:    rd_ext = {{16{sel_q[2] & rd_half[15]}}, rd_half};
      default: rd_ext = bus.bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    sel_d       = sel_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = '0;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    cause_d     = 2'b00;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_cause != 2'b00) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
            cause_d = req_cause;
          end else begin
            state_d     = BUS;
            we_d        = we;
            sel_d       = memSelect;
            lane_d      = addr[1:0];
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = we;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = req_be;
            bus_wdata_d = req_wdata;
          end
        end
      end
      BUS: begin
        if (bus.bus_ready || cnt_q == 9'(TIMEOUT - 1)) begin
          state_d     = DONE;
          done_d      = 1'b1;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
          if (bus.bus_ready) begin
            rdata_d = we_q ? 32'd0 : rd_ext;
          end else begin
            fault_d = 1'b1;
            cause_d = 2'b11;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      sel_q       <= '0;
      lane_q      <= '0;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      cause_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
    end
  end

  // Gated by reset so the core sees no stall while reset is held with req high.
  assign stall         = reset & ((state_q == IDLE & req) | state_q == BUS);
  assign rdata         = rdata_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store bus interface that sits directly downstream of the instruction decoder. It consumes the decoder's MemW and memSelect (size/sign) controls together with the ALU-computed address. It then performs one aligned access on a ready/valid data bus, with byte-lane steering, store-data replication, load extraction and sign/zero extension, misalignment checks and a bus timeout. While an access is in flight it stalls the core. It returns the extended load value to the write-back mux.

## Interface
- TIMEOUT, 16: maximum bus cycles spent waiting for bus_ready before aborting; range 2..256.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  memory instruction present and condition-passed (load or store).
- we  in  1  1 = store (decoder MemW), 0 = load.
- memSelect  in  3  [2] = signed load; [1:0] = size, where 0 = BYTE, 1 = HALF, 2 = WORD and 3 = reserved.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data; the low byte or halfword is used for BYTE/HALF stores.
- rdata  out  32  extended load result; valid while done=1.
- done  out  1  one-cycle completion pulse.
- fault  out  1  access aborted; valid with done.
- fault_cause  out  2  01 = misaligned, 10 = reserved size, 11 = timeout, 00 = none.
- stall  out  1  hold the core's PC and pipeline this cycle.
- bus_req  out  1  bus request (valid).
- bus_we  out  1  bus write.
- bus_addr  out  32  word-aligned address, addr[31:2],2'b00.
- bus_be  out  4  byte-lane enables; bit k selects bits 8k+7:8k.
- bus_wdata  out  32  lane-replicated store data.
- bus_ready  in  1  bus accepts the write, or returns read data, this cycle.
- bus_rdata  in  32  read data; sampled when bus_req & bus_ready.

## Operation
- The FSM has three states: IDLE, BUS and DONE.
- **IDLE**
  - With req=1 and a legal request: latch we, memSelect, addr and wdata; compute bus_be and bus_wdata; go to BUS.
  - With req=1 and an illegal request: go to DONE with fault set. No bus cycle is issued.
- **Illegal requests**
  - size=3 gives cause 10.
  - HALF with addr[0]=1 gives cause 01.
  - WORD with addr[1:0]≠0 gives cause 01.
  - When both apply, cause 10 takes precedence.
- **Lanes** (little-endian, k = addr[1:0])
  - BYTE: be = 1<<k; wdata = {4{wdata[7:0]}}.
  - HALF: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - WORD: be = 1111; wdata passed through.
- **BUS**
  - bus_req=1; bus_we, bus_addr, bus_be and bus_wdata are held stable until bus_ready.
  - On bus_ready=1: capture the extracted and extended load value (stores capture 0); go to DONE with fault=0.
  - The wait counter clears on entry to BUS and increments each cycle with bus_ready=0.
  - If the counter equals TIMEOUT-1 and bus_ready=0: go to DONE with cause 11. bus_req drops the next cycle.
- **Extraction**
  - BYTE: bus_rdata[8k+7:8k].
  - HALF: addr[1] ? [31:16] : [15:0].
  - memSelect[2]=1 sign-extends from bit 7 or bit 15; otherwise zero-extends. WORD ignores memSelect[2].
- **DONE**
  - done=1 for exactly one cycle; then return to IDLE unconditionally.
  - req is not sampled in DONE. The core advances on done, so a following access is accepted in the next IDLE cycle.
- **Fault completion**: rdata=0, and no bus write has occurred.
- **stall** (combinational): (state==IDLE & req) | state==BUS. It is 0 in DONE and 0 while reset is asserted.
- **Reset**: all registers clear, state becomes IDLE, and every output goes to 0 immediately (asynchronously), including mid-BUS. An interrupted bus cycle is abandoned, not retried.

## Timing
- Reset values are 0 for rdata, done, fault, fault_cause, stall, bus_req, bus_we, bus_addr, bus_be and bus_wdata.
- Accepted access with ready on the first BUS cycle:
  - req sampled in cycle 0.
  - bus_req high in cycle 1, with bus_ready in cycle 1.
  - done in cycle 2.
  - Minimum latency is 2 cycles; each wait state adds 1.
- Illegal request: done and fault in cycle 1; bus_req never asserts.
- Timeout: done occurs TIMEOUT+1 cycles after acceptance; bus_req is high for exactly TIMEOUT cycles.
- Throughput: at most one access per 3 cycles (IDLE, BUS, DONE).
- Bus outputs are registered and are 0 in IDLE and DONE.

## Test plan
- Signed LDRB: addr=0x1003, memSelect=100, bus_rdata=0x80xxxxxx, ready in first BUS cycle -> bus_be=1000, bus_addr=0x1000, done in cycle 2, rdata=0xFFFFFF80. Repeat with memSelect=000 -> rdata=0x00000080.
- STRH: addr=0x0102, wdata=0x1234ABCD, memSelect=001 -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x0100.
- Misaligned LDR at 0x0101; then size=3 at 0x0101 -> done in cycle 1, fault=1, cause 01 then 10, bus_req stays 0, rdata=0.
- Wait states: bus_ready held low 3 cycles then high, bus_rdata=0xDEADBEEF, WORD -> stall high through cycle 4, done in cycle 5, rdata=0xDEADBEEF. Back-to-back req is accepted in cycle 6.
- Timeout with TIMEOUT=16 and bus_ready tied 0 -> bus_req high exactly 16 cycles, done in cycle 17 with fault=1, cause 11; bus_req low afterwards.
- Reset asserted in the middle of the BUS state -> bus_req, stall and done drop without waiting for a clock edge. After release, the state is IDLE and a new request completes normally.
